// File: rtl/shift_seq.sv
// ============================================================================
// Module   : shift_seq
// Purpose  : Multi-cycle WIDTH-generic rotate-through-carry / shift unit,
//            one bit per clock, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    amount,
    input  logic             c_in,
    input  logic [WIDTH-1:0] oprd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [1:0] c_md_rrf = 2'b00;
    localparam logic [1:0] c_md_rlf = 2'b01;
    localparam logic [1:0] c_md_asr = 2'b10;
    localparam logic [1:0] c_md_lsl = 2'b11;

    localparam logic [AW-1:0] c_cnt_one = AW'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic             r_wc;
    logic [AW-1:0]    r_cnt;
    logic [1:0]       r_md;
    logic [WIDTH-1:0] r_s_out;
    logic             r_c_out;
    logic [WIDTH-1:0] w_step_work;
    logic             w_step_wc;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = (amount != '0) ? c_st_shift : c_st_done;
                end
            end
            c_st_shift: begin
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Output decode, taken straight from the state register
    always_comb begin
        busy = (r_state != c_st_idle);
        done = (r_state == c_st_done);
    end

    // One-bit step on the {carry, work} pair
    always_comb begin
        w_step_work = r_work;
        w_step_wc   = r_wc;
        case (r_md)
            c_md_rlf: {w_step_wc, w_step_work} = {r_work, r_wc};
            c_md_rrf: {w_step_wc, w_step_work} = {r_work[0], r_wc, r_work[WIDTH-1:1]};
            c_md_lsl: {w_step_wc, w_step_work} = {r_work, 1'b0};
            c_md_asr: {w_step_wc, w_step_work} = {r_work[0], r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default:  {w_step_wc, w_step_work} = {r_wc, r_work};
        endcase
    end

    // Result registers are written on the edge that enters DONE so the new
    // value is visible in the same cycle as the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_wc    <= 1'b0;
            r_cnt   <= '0;
            r_md    <= 2'b00;
            r_s_out <= '0;
            r_c_out <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_work <= oprd;
                        r_wc   <= c_in;
                        r_md   <= mode;
                        r_cnt  <= amount;
                        if (amount == '0) begin
                            r_s_out <= oprd;
                            r_c_out <= c_in;
                        end
                    end
                end
                c_st_shift: begin
                    r_work <= w_step_work;
                    r_wc   <= w_step_wc;
                    r_cnt  <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_s_out <= w_step_work;
                        r_c_out <= w_step_wc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_out = r_s_out;
    assign c_out = r_c_out;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq.sv
// ============================================================================
// Module   : tb_shift_seq
// Purpose  : Self-checking bench for shift_seq at WIDTH = 8, 16 and 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq;

    logic clk;
    logic rst_n;

    logic [2:0][15:0] oprd_a;
    logic [2:0][4:0]  amt_a;
    logic [2:0][1:0]  mode_a;
    logic [2:0]       cin_a;
    logic [2:0]       start_a;
    logic [2:0][15:0] s_a;
    logic [2:0]       c_a;
    logic [2:0]       busy_a;
    logic [2:0]       done_a;

    int n_cmp;
    int n_bad;
    bit chk_en;

    // Reference state per instance
    int          left [3];
    int          cyc  [3];
    logic [16:0] pend [3];
    logic [15:0] es   [3];
    logic        ec   [3];

    // Hand-computed expectations for the current operation
    bit          lit_arm [3];
    logic [15:0] lit_s   [3];
    logic        lit_c   [3];
    int          lit_cyc [3];

    function automatic int wid(input int g);
        return (g == 0) ? 8 : (g == 1) ? 16 : 2;
    endfunction

    function automatic int awid(input int g);
        return $clog2(wid(g) + 2);
    endfunction

    function automatic logic [15:0] wmask(input int g);
        logic [31:0] m;
        m = (32'd1 << wid(g)) - 32'd1;
        return m[15:0];
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 2;
            localparam int A = $clog2(W + 2);
            logic [W-1:0] s;
            logic         c, b, d;
            shift_seq #(.WIDTH(W), .AW(A)) u_dut (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (start_a[g]),
                .mode   (mode_a[g]),
                .amount (amt_a[g][A-1:0]),
                .c_in   (cin_a[g]),
                .oprd   (oprd_a[g][W-1:0]),
                .busy   (b),
                .done   (d),
                .s_out  (s),
                .c_out  (c)
            );
            assign s_a[g]    = 16'(s);
            assign c_a[g]    = c;
            assign busy_a[g] = b;
            assign done_a[g] = d;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed-form result: rotates are a (w+1)-bit ring, shifts are plain
    // arithmetic with the last bit shifted out as carry.
    function automatic logic [16:0] ref_op(input int w, input logic [1:0] md, input int amt,
                                           input logic ci, input logic [15:0] op_in);
        longint m, op, v, r, s;
        int     k, sh;
        logic   c;
        m  = (64'sd1 <<< w) - 1;
        op = longint'(op_in) & m;
        if (amt == 0) return {ci, op_in & 16'(m)};
        s = 0;
        c = 1'b0;
        case (md)
            2'b00, 2'b01: begin
                v = (longint'(ci) << w) | op;
                k = amt % (w + 1);
                if (md == 2'b00) k = (w + 1 - k) % (w + 1);
                r = ((v << k) | (v >> (w + 1 - k))) & ((m << 1) | 1);
                s = r & m;
                c = r[w];
            end
            2'b11: begin
                s = (op << amt) & m;
                c = (amt <= w) ? op[w-amt] : 1'b0;
            end
            default: begin
                sh = (amt >= w) ? w : amt;
                if (op[w-1]) op = op | ~m;
                s = (op >>> sh) & m;
                c = (amt <= w) ? op[amt-1] : op[w-1];
            end
        endcase
        return {c, s[15:0]};
    endfunction

    // Cycle-level reference: accept when idle, then busy for amount+1 cycles
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
                left[g] = 0;
                es[g]   = '0;
                ec[g]   = 1'b0;
            end else begin
                if (left[g] > 0) begin
                    left[g] = left[g] - 1;
                    cyc[g]  = cyc[g] + 1;
                end else if (start_a[g]) begin
                    pend[g] = ref_op(wid(g), mode_a[g], int'(amt_a[g]) & ((1 << awid(g)) - 1),
                                     cin_a[g], oprd_a[g]);
                    left[g] = (int'(amt_a[g]) & ((1 << awid(g)) - 1)) + 1;
                    cyc[g]  = 1;
                end
                if (left[g] == 1) {ec[g], es[g]} = pend[g];
            end
        end
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s w=%0d t=%0t: got %0h, expected %0h", nm, wid(g), $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 3; g++) begin
                chk("busy",  g, 32'(busy_a[g]), 32'(left[g] > 0));
                chk("done",  g, 32'(done_a[g]), 32'(left[g] == 1));
                chk("s_out", g, 32'(s_a[g] & wmask(g)), 32'(es[g]));
                chk("c_out", g, 32'(c_a[g]), 32'(ec[g]));
                if (lit_arm[g] && left[g] == 1) begin
                    chk("lat_lit",   g, 32'(cyc[g]), 32'(lit_cyc[g]));
                    chk("s_lit",     g, 32'(s_a[g] & wmask(g)), 32'(lit_s[g]));
                    chk("c_lit",     g, 32'(c_a[g]), 32'(lit_c[g]));
                    chk("model_lit", g, 32'(es[g]), 32'(lit_s[g]));
                end
            end
        end
    end

    task automatic run_op(input int g, input logic [1:0] md, input int amt, input logic ci,
                          input logic [15:0] op, input bit lit, input logic [15:0] ls,
                          input logic lc, input bit disturb, input bit rst_mid);
        int k;
        @(negedge clk);
        lit_arm[g] = lit;
        lit_s[g]   = ls;
        lit_c[g]   = lc;
        lit_cyc[g] = amt + 1;
        start_a[g] = 1'b1;
        mode_a[g]  = md;
        amt_a[g]   = 5'(amt);
        cin_a[g]   = ci;
        oprd_a[g]  = op & wmask(g);
        @(negedge clk);
        start_a[g] = 1'b0;
        if (disturb) begin
            start_a[g] = 1'b1;
            mode_a[g]  = ~md;
            amt_a[g]   = 5'(amt + 3);
            cin_a[g]   = ~ci;
            oprd_a[g]  = ~op & wmask(g);
            @(negedge clk);
            start_a[g] = 1'b0;
        end
        if (rst_mid) begin
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (6) @(negedge clk);
            return;
        end
        k = 0;
        while (left[g] != 1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            $display("FAIL timeout w=%0d: done never reached, expected after %0d cycles", wid(g), amt + 1);
            $fatal(1, "timeout");
        end
    endtask

    logic [1:0]  t_md  [9] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11, 2'b01, 2'b10};
    int          t_amt [9] = '{2, 1, 1, 9, 2, 3, 12, 0, 4};
    logic        t_ci  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  t_op  [9] = '{8'h81, 8'h81, 8'h01, 8'h5A, 8'hC3, 8'h80, 8'hFF, 8'h3C, 8'h96};

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        chk_en  = 1'b0;
        rst_n   = 1'b0;
        oprd_a  = '0;
        amt_a   = '0;
        mode_a  = '0;
        cin_a   = '0;
        start_a = '0;
        for (int g = 0; g < 3; g++) begin
            lit_arm[g] = 1'b0;
            left[g]    = 0;
            cyc[g]     = 0;
            pend[g]    = '0;
            es[g]      = '0;
            ec[g]      = 1'b0;
        end
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH = 8 directed vectors
        run_op(0, 2'b01,  2, 1'b0, 16'h81, 1, 16'h05, 1'b0, 0, 0);
        run_op(0, 2'b01,  1, 1'b0, 16'h81, 1, 16'h02, 1'b1, 0, 0);
        run_op(0, 2'b00,  1, 1'b1, 16'h01, 1, 16'h80, 1'b1, 0, 0);
        repeat (3) @(negedge clk);
        run_op(0, 2'b00,  9, 1'b1, 16'h5A, 1, 16'h5A, 1'b1, 0, 0);
        run_op(0, 2'b11,  2, 1'b0, 16'hC3, 1, 16'h0C, 1'b1, 0, 0);
        run_op(0, 2'b10,  3, 1'b0, 16'h80, 1, 16'hF0, 1'b0, 0, 0);
        run_op(0, 2'b11, 12, 1'b0, 16'hFF, 1, 16'h00, 1'b0, 0, 0);
        run_op(0, 2'b01,  0, 1'b1, 16'h3C, 1, 16'h3C, 1'b1, 0, 0);
        repeat (2) @(negedge clk);
        run_op(0, 2'b10,  4, 1'b1, 16'h96, 1, 16'hF9, 1'b0, 1, 0);
        run_op(0, 2'b01,  5, 1'b0, 16'hA5, 0, 16'h00, 1'b0, 0, 1);
        run_op(0, 2'b01,  3, 1'b1, 16'hF0, 0, 16'h00, 1'b0, 0, 0);

        // WIDTH = 16 and WIDTH = 2 hand-computed points
        run_op(1, 2'b01,  2, 1'b0, 16'h8001, 1, 16'h0005, 1'b0, 0, 0);
        run_op(1, 2'b10,  3, 1'b0, 16'h8000, 1, 16'hF000, 1'b0, 0, 0);
        run_op(1, 2'b00, 17, 1'b1, 16'h1234, 1, 16'h1234, 1'b1, 0, 0);
        run_op(2, 2'b01,  3, 1'b0, 16'h2, 1, 16'h2, 1'b0, 0, 0);
        run_op(2, 2'b11,  3, 1'b0, 16'h3, 1, 16'h0, 1'b0, 0, 0);
        run_op(2, 2'b10,  1, 1'b0, 16'h2, 1, 16'h3, 1'b0, 0, 0);
        run_op(2, 2'b00,  1, 1'b0, 16'h1, 1, 16'h0, 1'b1, 0, 0);

        // Same scenario table at the other widths, checked against the model
        for (int g = 1; g < 3; g++) begin
            for (int i = 0; i < 9; i++) begin
                int a;
                a = t_amt[i];
                if (a > (1 << awid(g)) - 1) a = (1 << awid(g)) - 1;
                run_op(g, t_md[i], a, t_ci[i], {t_op[i], t_op[i] ^ 8'hA5}, 0, 16'h0, 1'b0,
                       (i == 8 && a >= 2), 0);
                if (i % 3 == 0) repeat (2) @(negedge clk);
            end
            run_op(g, 2'b01, wid(g) + 1, 1'b1, 16'h5A3C, 0, 16'h0, 1'b0, 0, 0);
            run_op(g, 2'b01, 3, 1'b0, 16'hA5A5, 0, 16'h0, 1'b0, 0, 1);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_seq.md
# shift_seq

Multi-cycle, parametrised rotate/shift unit: the WIDTH-generic successor of the team's 8-bit rotate-through-carry datapath. It executes one-bit steps per clock, up to a requested amount, in one of four modes: rotate left or right through carry, logical shift left, or arithmetic shift right. It sits beside the ALU and is driven by the CPU control FSM through a start/busy/done handshake. Final result and carry are held on registered outputs until the next operation completes.

## Interface
- WIDTH, 8, operand/result width (≥2)
- AW, $clog2(WIDTH+2), width of the shift-amount port
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- mode  in  2  mode[0]: 1 = left, 0 = right; mode[1]: 0 = rotate through carry, 1 = shift (left logical / right arithmetic)
- amount  in  AW  number of one-bit steps, 0..2^AW-1
- c_in  in  1  carry input
- oprd  in  WIDTH  operand
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; s_out/c_out valid and updated that cycle
- s_out  out  WIDTH  result, registered, held between operations
- c_out  out  1  carry result, registered, held between operations

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers: work[WIDTH-1:0], wc, cnt[AW-1:0], md[1:0].
- IDLE, start=1:
  - Load work←oprd, wc←c_in, md←mode, cnt←amount.
  - Next state SHIFT if amount≠0, else DONE.
- IDLE, start=0: stay in IDLE.
- SHIFT: apply one step per cycle and decrement cnt. Move to DONE on the step where cnt==1; otherwise stay in SHIFT.
- Step definitions:
  - md=01 (RLF): {wc,work} ← {work, wc}
  - md=00 (RRF): {wc,work} ← {work[0], wc, work[WIDTH-1:1]}
  - md=11 (LSL): {wc,work} ← {work, 1'b0}
  - md=10 (ASR): {wc,work} ← {work[0], work[WIDTH-1], work[WIDTH-1:1]}
- Rotate modes have period WIDTH+1: amount=WIDTH+1 returns the operand and carry unchanged.
- Shift modes: c_out = last bit shifted out. For amount≥WIDTH, LSL gives 0 and ASR gives all copies of the sign bit. No saturation of amount; every step is executed.
- amount=0: s_out=oprd, c_out=c_in for all modes.
- DONE:
  - On entry, s_out←work and c_out←wc.
  - done=1 for exactly this cycle; next state IDLE.
- start is ignored while busy=1 (no queueing). A start in the cycle after DONE is accepted normally.
- mode, amount, c_in and oprd are sampled only at the accepting edge; later changes have no effect.
- Reset (rst_n=0 at any edge, including mid-SHIFT or in DONE):
  - Next state is IDLE; busy=0, done=0, s_out=0, c_out=0, internal registers cleared.
  - The in-flight operation is discarded and no done pulse is issued.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start sampled at edge 0 (cycle 0):
  - SHIFT occupies cycles 1..N for N=amount.
  - DONE occupies cycle N+1 (done=1, new s_out/c_out visible).
  - IDLE is reached in cycle N+2.
- amount=0: done in cycle 1.
- busy is high in cycles 1..N+1.
- Throughput: one operation per N+2 cycles. A back-to-back start may be asserted in cycle N+2.

## Test plan
- Reset, WIDTH=8: hold rst_n=0 for 2 cycles → busy=0, done=0, s_out=0x00, c_out=0. Assert rst_n=0 in cycle 2 of an amount=5 op → IDLE next cycle, no done pulse, outputs 0.
- RLF: oprd=0x81, c_in=0, amount=2 → done in cycle 3, s_out=0x05, c_out=0. Same with amount=1 → s_out=0x02, c_out=1, done in cycle 2.
- RRF: oprd=0x01, c_in=1, amount=1 → s_out=0x80, c_out=1. oprd=0x5A, c_in=1, amount=9 → s_out=0x5A, c_out=1, done in cycle 10.
- Shifts:
  - LSL oprd=0xC3, c_in=0, amount=2 → s_out=0x0C, c_out=1.
  - ASR oprd=0x80, amount=3 → s_out=0xF0, c_out=0.
  - LSL oprd=0xFF, amount=12 → s_out=0x00, c_out=0.
- Boundaries:
  - amount=0, oprd=0x3C, c_in=1 → done in cycle 1, s_out=0x3C, c_out=1.
  - start pulsed while busy → ignored, result unchanged.
  - Inputs changed during SHIFT → no effect on result.
- Parameter sweep: repeat all scenarios at WIDTH=16 and WIDTH=2 against a reference step model. Check that done appears exactly amount+1 cycles after start, and that s_out/c_out hold between operations.
